// File: rtl/sram_axi_bridge_mp.sv
// sram_axi_bridge_mp: bridges NUM_PORTS SRAM-like masters onto one AXI3 master.
// Port k uses AXI ID k. Each port keeps up to OUTSTANDING requests in flight and
// gets its responses back in its own request order.
// Optional build macro SRAM_AXI_RR_ARB_EN: round-robin arbitration (separate
// read / write pointers). Without it, the highest requesting port index wins.
//
// Handshakes: an AXI beat transfers on any cycle where valid & ready are both
// high; valid never drops before its transfer and the payload holds while
// waiting. On the SRAM side a request is taken on req & addr_ok (addr_ok is
// combinational), and data_ok is a one-cycle response strobe per port.
module sram_axi_bridge_mp #(
    parameter int NUM_PORTS   = 2,
    parameter int OUTSTANDING = 4,
    parameter int PTR_W       = 2
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    // AR channel
    output logic [3:0]                arid,
    output logic [31:0]               araddr,
    output logic [3:0]                arlen,
    output logic [2:0]                arsize,
    output logic [1:0]                arburst,
    output logic [1:0]                arlock,
    output logic [3:0]                arcache,
    output logic [2:0]                arprot,
    output logic                      arvalid,
    input  logic                      arready,
    // R channel
    input  logic [3:0]                rid,
    input  logic [31:0]               rdata,
    input  logic [1:0]                rresp,
    input  logic                      rlast,
    input  logic                      rvalid,
    output logic                      rready,
    // AW channel
    output logic [3:0]                awid,
    output logic [31:0]               awaddr,
    output logic [3:0]                awlen,
    output logic [2:0]                awsize,
    output logic [1:0]                awburst,
    output logic [1:0]                awlock,
    output logic [3:0]                awcache,
    output logic [2:0]                awprot,
    output logic                      awvalid,
    input  logic                      awready,
    // W channel
    output logic [3:0]                wid,
    output logic [31:0]               wdata,
    output logic [3:0]                wstrb,
    output logic                      wlast,
    output logic                      wvalid,
    input  logic                      wready,
    // B channel
    input  logic [3:0]                bid,
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready,
    // SRAM-like ports
    input  logic [NUM_PORTS-1:0]      sram_req,
    input  logic [NUM_PORTS-1:0]      sram_wr,
    input  logic [2*NUM_PORTS-1:0]    sram_size,
    input  logic [4*NUM_PORTS-1:0]    sram_wstrb,
    input  logic [32*NUM_PORTS-1:0]   sram_addr,
    input  logic [32*NUM_PORTS-1:0]   sram_wdata,
    output logic [NUM_PORTS-1:0]      sram_addr_ok,
    output logic [NUM_PORTS-1:0]      sram_data_ok,
    output logic [32*NUM_PORTS-1:0]   sram_rdata
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW = PTR_W + 1;

    // Single-beat, incrementing, normal access on both address channels.
    assign arlen   = 4'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign awlen   = 4'd0;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign wlast   = 1'b1;

    // Response codes and rlast carry no information for single-beat, error-tolerant returns.
    logic unused_inputs;
    assign unused_inputs = ^{rresp, rlast, bresp};

    // Per-port status gathered from the per-port blocks
    logic [NUM_PORTS-1:0]           ord_full, ord_nempty, ord_head_wr;
    logic [NUM_PORTS-1:0]           rf_full, rf_nempty, ack_full, ack_nz;
    logic [NUM_PORTS*NUM_PORTS-1:0] haz_flat;  // [k*NUM_PORTS+p]: port k's CAM hits port p's address
    logic [NUM_PORTS-1:0]           haz, r_sel, b_sel, r_push, b_push;
    logic [NUM_PORTS-1:0]           rd_elig, wr_elig, rd_gnt, wr_gnt;
    logic [PW-1:0]                  rd_idx, wr_idx;
    logic                           rd_any, wr_any, ar_free, w_free, rd_acc, wr_acc;
    logic                           rdy_en;
    logic [31:0]                    rd_addr, wr_addr, wr_data;
    logic [1:0]                     rd_size, wr_size;
    logic [3:0]                     wr_strb;

    // Eligibility: a port may compete only if its order FIFO has room; reads also need no RAW hit.
    always_comb begin
        haz = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                haz[p] = haz[p] | haz_flat[k*NUM_PORTS + p];
            end
        end
        rd_elig = sram_req & ~sram_wr & ~ord_full & ~haz;
        wr_elig = sram_req &  sram_wr & ~ord_full;
    end

`ifdef SRAM_AXI_RR_ARB_EN
    logic [PW-1:0] rd_ptr, wr_ptr;
    int            rj, wj;

    // Round-robin: search upward from the pointer, first eligible port wins.
    always_comb begin
        rd_any = 1'b0;
        wr_any = 1'b0;
        rd_idx = '0;
        wr_idx = '0;
        rj     = 0;
        wj     = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            rj = int'(rd_ptr) + i;
            if (rj >= NUM_PORTS) rj = rj - NUM_PORTS;
            wj = int'(wr_ptr) + i;
            if (wj >= NUM_PORTS) wj = wj - NUM_PORTS;
            if (!rd_any && rd_elig[rj]) begin
                rd_any = 1'b1;
                rd_idx = PW'(rj);
            end
            if (!wr_any && wr_elig[wj]) begin
                wr_any = 1'b1;
                wr_idx = PW'(wj);
            end
        end
    end

    // Pointers move past the winner only when its request is actually accepted.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (rd_acc) rd_ptr <= (int'(rd_idx) == NUM_PORTS-1) ? '0 : rd_idx + 1'b1;
            if (wr_acc) wr_ptr <= (int'(wr_idx) == NUM_PORTS-1) ? '0 : wr_idx + 1'b1;
        end
    end
`else
    // Fixed priority: the highest eligible port index wins (data over inst).
    always_comb begin
        rd_any = 1'b0;
        wr_any = 1'b0;
        rd_idx = '0;
        wr_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (rd_elig[i]) begin
                rd_any = 1'b1;
                rd_idx = PW'(i);
            end
            if (wr_elig[i]) begin
                wr_any = 1'b1;
                wr_idx = PW'(i);
            end
        end
    end
`endif

    // Grant vectors, payload muxes and the combinational addr_ok.
    always_comb begin
        rd_gnt  = '0;
        wr_gnt  = '0;
        rd_addr = '0;
        rd_size = '0;
        wr_addr = '0;
        wr_size = '0;
        wr_data = '0;
        wr_strb = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            rd_gnt[k] = rd_any && (int'(rd_idx) == k);
            wr_gnt[k] = wr_any && (int'(wr_idx) == k);
            if (rd_gnt[k]) begin
                rd_addr = sram_addr[k*32 +: 32];
                rd_size = sram_size[k*2 +: 2];
            end
            if (wr_gnt[k]) begin
                wr_addr = sram_addr[k*32 +: 32];
                wr_size = sram_size[k*2 +: 2];
                wr_data = sram_wdata[k*32 +: 32];
                wr_strb = sram_wstrb[k*4 +: 4];
            end
        end
        ar_free      = !arvalid || arready;
        w_free       = (!awvalid || awready) && (!wvalid || wready);
        rd_acc       = rd_any && ar_free;
        wr_acc       = wr_any && w_free;
        sram_addr_ok = (rd_gnt & {NUM_PORTS{ar_free}}) | (wr_gnt & {NUM_PORTS{w_free}});
    end

    // AR slot: loads on an accepted read (even in the cycle arready drains it), clears on arready.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            arvalid <= 1'b0;
            arid    <= '0;
            araddr  <= '0;
            arsize  <= '0;
        end else if (rd_acc) begin
            arvalid <= 1'b1;
            arid    <= 4'(rd_idx);
            araddr  <= rd_addr;
            arsize  <= {1'b0, rd_size};
        end else if (arready) begin
            arvalid <= 1'b0;
        end
    end

    // AW and W slots load together; each then drains on its own handshake.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            awid    <= '0;
            awaddr  <= '0;
            awsize  <= '0;
            wid     <= '0;
            wdata   <= '0;
            wstrb   <= '0;
        end else if (wr_acc) begin
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            awid    <= 4'(wr_idx);
            awaddr  <= wr_addr;
            awsize  <= {1'b0, wr_size};
            wid     <= 4'(wr_idx);
            wdata   <= wr_data;
            wstrb   <= wr_strb;
        end else begin
            if (awready) awvalid <= 1'b0;
            if (wready)  wvalid  <= 1'b0;
        end
    end

    // rready/bready are held off for the first cycle out of reset.
    always_ff @(posedge aclk) begin
        rdy_en <= aresetn;
    end

    // Route R/B returns by ID; unknown IDs are always accepted and dropped.
    always_comb begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            r_sel[k] = (rid == 4'(k));
            b_sel[k] = (bid == 4'(k));
        end
        rready = rdy_en && (!(|r_sel) || (|(r_sel & ~rf_full)));
        bready = rdy_en && (!(|b_sel) || (|(b_sel & ~ack_full)));
        r_push = r_sel & {NUM_PORTS{rvalid && rready}};
        b_push = b_sel & {NUM_PORTS{bvalid && bready}};
    end

    // Response strobe: the oldest request of a port completes once its return is stored.
    always_comb begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            sram_data_ok[k] = ord_nempty[k] && (ord_head_wr[k] ? ack_nz[k] : rf_nempty[k]);
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        logic [OUTSTANDING-1:0] ord_mem;
        logic [PTR_W-1:0]       ord_wp, ord_rp, rf_wp, rf_rp, cam_wp, cam_rp;
        logic [CW-1:0]          ord_cnt, rf_cnt, ack_cnt;
        logic [31:0]            rf_mem [OUTSTANDING];
        logic [29:0]            cam_addr [OUTSTANDING];
        logic [OUTSTANDING-1:0] cam_vld;
        logic [NUM_PORTS-1:0]   match;
        logic                   ord_push, ord_pop, rf_pop, ack_dec, cam_push;

        assign ord_push = sram_addr_ok[g];
        assign ord_pop  = sram_data_ok[g];
        assign rf_pop   = sram_data_ok[g] & ~ord_head_wr[g];
        assign ack_dec  = sram_data_ok[g] &  ord_head_wr[g];
        assign cam_push = sram_addr_ok[g] &  sram_wr[g];

        // Order FIFO: one bit per accepted request, 1 = write.
        always_ff @(posedge aclk) begin
            if (!aresetn) begin
                ord_wp  <= '0;
                ord_rp  <= '0;
                ord_cnt <= '0;
                ord_mem <= '0;
            end else begin
                if (ord_push) begin
                    ord_mem[ord_wp] <= sram_wr[g];
                    ord_wp          <= ord_wp + 1'b1;
                end
                if (ord_pop) ord_rp <= ord_rp + 1'b1;
                if (ord_push && !ord_pop)      ord_cnt <= ord_cnt + 1'b1;
                else if (!ord_push && ord_pop) ord_cnt <= ord_cnt - 1'b1;
            end
        end

        // Read-data FIFO pointers and occupancy.
        always_ff @(posedge aclk) begin
            if (!aresetn) begin
                rf_wp  <= '0;
                rf_rp  <= '0;
                rf_cnt <= '0;
            end else begin
                if (r_push[g]) rf_wp <= rf_wp + 1'b1;
                if (rf_pop)    rf_rp <= rf_rp + 1'b1;
                if (r_push[g] && !rf_pop)      rf_cnt <= rf_cnt + 1'b1;
                else if (!r_push[g] && rf_pop) rf_cnt <= rf_cnt - 1'b1;
            end
        end

        // Read-data FIFO storage (no reset needed, guarded by rf_cnt).
        always_ff @(posedge aclk) begin
            if (r_push[g]) rf_mem[rf_wp] <= rdata;
        end

        // Write-ack counter: B returns waiting for their order slot.
        always_ff @(posedge aclk) begin
            if (!aresetn) begin
                ack_cnt <= '0;
            end else if (b_push[g] && !ack_dec) begin
                ack_cnt <= ack_cnt + 1'b1;
            end else if (!b_push[g] && ack_dec) begin
                ack_cnt <= ack_cnt - 1'b1;
            end
        end

        // Write CAM: same-ID B returns arrive in issue order, so the oldest entry is freed.
        always_ff @(posedge aclk) begin
            if (!aresetn) begin
                cam_wp  <= '0;
                cam_rp  <= '0;
                cam_vld <= '0;
            end else begin
                if (b_push[g]) begin
                    cam_vld[cam_rp] <= 1'b0;
                    cam_rp          <= cam_rp + 1'b1;
                end
                if (cam_push) begin
                    cam_vld[cam_wp] <= 1'b1;
                    cam_wp          <= cam_wp + 1'b1;
                end
            end
        end

        // Write CAM address storage, word granularity.
        always_ff @(posedge aclk) begin
            if (cam_push) cam_addr[cam_wp] <= sram_addr[g*32+2 +: 30];
        end

        // Compare every live entry against each port's current word address.
        always_comb begin
            match = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                for (int e = 0; e < OUTSTANDING; e++) begin
                    if (cam_vld[e] && (cam_addr[e] == sram_addr[p*32+2 +: 30])) match[p] = 1'b1;
                end
            end
        end

        assign haz_flat[g*NUM_PORTS +: NUM_PORTS] = match;
        assign ord_full[g]    = (ord_cnt == CW'(OUTSTANDING));
        assign ord_nempty[g]  = (ord_cnt != '0);
        assign ord_head_wr[g] = ord_mem[ord_rp];
        assign rf_full[g]     = (rf_cnt == CW'(OUTSTANDING));
        assign rf_nempty[g]   = (rf_cnt != '0);
        assign ack_full[g]    = (ack_cnt == CW'(OUTSTANDING));
        assign ack_nz[g]      = (ack_cnt != '0);
        assign sram_rdata[g*32 +: 32] = rf_mem[rf_rp];
    end

endmodule

// File: tb/tb_sram_axi_bridge_mp.sv
// Directed bench for sram_axi_bridge_mp (NUM_PORTS=2, OUTSTANDING=4).
// The bench plays the AXI slave by hand; expectations are hand-computed.
module tb_sram_axi_bridge_mp;

    localparam int N = 2;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic [3:0]  arid, awid, wid, rid, bid, arlen, awlen, arcache, awcache, wstrb;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
    logic        arvalid, arready, awvalid, awready, wvalid, wready, wlast;
    logic        rlast, rvalid, rready, bvalid, bready;
    logic [N-1:0]    sram_req, sram_wr, sram_addr_ok, sram_data_ok;
    logic [2*N-1:0]  sram_size;
    logic [4*N-1:0]  sram_wstrb;
    logic [32*N-1:0] sram_addr, sram_wdata, sram_rdata;

    sram_axi_bridge_mp #(.NUM_PORTS(N), .OUTSTANDING(4), .PTR_W(2)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size), .sram_wstrb(sram_wstrb),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_addr_ok(sram_addr_ok),
        .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Present a request on port p and hold it until accepted (bounded).
    task automatic do_req(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
        int t;
        t = 0;
        sram_req[p] = 1'b1;
        sram_wr[p] = w;
        sram_addr[p*32 +: 32] = a;
        sram_wdata[p*32 +: 32] = d;
        sram_size[p*2 +: 2] = 2'd2;
        sram_wstrb[p*4 +: 4] = 4'hF;
        #1;
        while (!sram_addr_ok[p] && t < 20) begin
            @(posedge aclk);
            #2;
            t++;
        end
        check("accept", 32'(sram_addr_ok[p]), 1);
        step();
        sram_req[p] = 1'b0;
    endtask

    task automatic ar_take(input logic [3:0] id, input logic [31:0] a);
        int t;
        t = 0;
        #1;
        while (!arvalid && t < 20) begin
            @(posedge aclk);
            #2;
            t++;
        end
        check("arvalid", 32'(arvalid), 1);
        check("arid", 32'(arid), 32'(id));
        check("araddr", araddr, a);
        arready = 1'b1;
        step();
        arready = 1'b0;
    endtask

    task automatic aw_take(input logic [3:0] id, input logic [31:0] a, input logic [31:0] d);
        int t;
        t = 0;
        #1;
        while (!awvalid && t < 20) begin
            @(posedge aclk);
            #2;
            t++;
        end
        check("awvalid", 32'(awvalid), 1);
        check("awid", 32'(awid), 32'(id));
        check("awaddr", awaddr, a);
        check("wvalid", 32'(wvalid), 1);
        check("wdata", wdata, d);
        check("wstrb", 32'(wstrb), 32'hF);
        awready = 1'b1;
        wready = 1'b1;
        step();
        awready = 1'b0;
        wready = 1'b0;
    endtask

    // One R beat; returns at edge+2 so the caller can see data_ok.
    task automatic r_return(input logic [3:0] id, input logic [31:0] d);
        rid = id;
        rdata = d;
        rresp = 2'b00;
        rlast = 1'b1;
        rvalid = 1'b1;
        #1;
        check("rready", 32'(rready), 1);
        step();
        rvalid = 1'b0;
        #1;
    endtask

    task automatic b_return(input logic [3:0] id);
        bid = id;
        bresp = 2'b00;
        bvalid = 1'b1;
        #1;
        check("bready", 32'(bready), 1);
        step();
        bvalid = 1'b0;
        #1;
    endtask

    task automatic do_reset(input int cycles);
        #1;
        aresetn = 1'b0;
        repeat (cycles) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        #1;
    endtask

    initial begin
        sram_req = '0; sram_wr = '0; sram_size = '0; sram_wstrb = '0;
        sram_addr = '0; sram_wdata = '0;
        arready = 0; awready = 0; wready = 0;
        rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        bid = 0; bresp = 0; bvalid = 0;

        // Reset state
        do_reset(3);
        check("rst_arvalid", 32'(arvalid), 0);
        check("rst_awvalid", 32'(awvalid), 0);
        check("rst_wvalid", 32'(wvalid), 0);
        check("rst_data_ok", 32'(sram_data_ok), 0);
        check("arburst", 32'(arburst), 1);
        check("awburst", 32'(awburst), 1);
        check("wlast", 32'(wlast), 1);

        // 1: port0 read, data three cycles later
        do_req(0, 1'b0, 32'h1000, 0);
        ar_take(4'd0, 32'h1000);
        repeat (3) step();
        r_return(4'd0, 32'hDEADBEEF);
        check("t1_data_ok", 32'(sram_data_ok), 32'b01);
        check("t1_rdata", sram_rdata[31:0], 32'hDEADBEEF);
        step();
        check("t1_pulse", 32'(sram_data_ok), 0);

        // 2: write then read same word on port1 -> read stalls until B
        do_req(1, 1'b1, 32'h2000, 32'h12345678);
        aw_take(4'd1, 32'h2000, 32'h12345678);
        sram_req[1] = 1'b1;
        sram_wr[1] = 1'b0;
        sram_addr[63:32] = 32'h2000;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t2_raw_stall", 32'(sram_addr_ok[1]), 0);
            step();
        end
        b_return(4'd1);
        check("t2_raw_release", 32'(sram_addr_ok[1]), 1);
        check("t2_wr_ack", 32'(sram_data_ok), 32'b10);
        step();
        sram_req[1] = 1'b0;
        ar_take(4'd1, 32'h2000);
        r_return(4'd1, 32'hCAFEF00D);
        check("t2_data_ok", 32'(sram_data_ok), 32'b10);
        check("t2_rdata", sram_rdata[63:32], 32'hCAFEF00D);

        // 3: four outstanding reads fill port0, fifth stalls until a return
        arready = 1'b1;
        @(posedge aclk);
        for (int i = 0; i < 4; i++) begin
            #1;
            sram_req[0] = 1'b1;
            sram_wr[0] = 1'b0;
            sram_addr[31:0] = 32'h3000 + 32'(4 * i);
            #1;
            check("t3_fill", 32'(sram_addr_ok[0]), 1);
            @(posedge aclk);
        end
        #1;
        sram_addr[31:0] = 32'h3010;
        #1;
        check("t3_full_stall", 32'(sram_addr_ok[0]), 0);
        r_return(4'd0, 32'h11111111);
        check("t3_first_ok", 32'(sram_data_ok[0]), 1);
        check("t3_first_data", sram_rdata[31:0], 32'h11111111);
        @(posedge aclk);
        #2;
        check("t3_reenable", 32'(sram_addr_ok[0]), 1);
        step();
        sram_req[0] = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0 + 32'(i));
        for (int i = 0; i < 4; i++) begin
            r_return(4'd0, 32'hA0 + 32'(i));
            check("t3_drain_ok", 32'(sram_data_ok[0]), 1);
            check("t3_drain_data", sram_rdata[31:0], exp_q.pop_front());
        end
        arready = 1'b0;

        // 4: both ports read every cycle (arready held high)
        arready = 1'b1;
        @(posedge aclk);
        for (int i = 0; i < 4; i++) begin
            #1;
            sram_req = 2'b11;
            sram_wr = 2'b00;
            sram_addr = {32'h5000 + 32'(4 * i), 32'h4000 + 32'(4 * i)};
            #1;
`ifdef SRAM_AXI_RR_ARB_EN
            check("t4_grant", 32'(sram_addr_ok), (i % 2 == 0) ? 32'b10 : 32'b01);
`else
            check("t4_grant", 32'(sram_addr_ok), 32'b10);
`endif
            @(posedge aclk);
        end
        #1;
        sram_req = 2'b00;
        arready = 1'b0;
        do_reset(1);

        // 6: reset with two reads outstanding (one still waiting on AR)
        do_req(0, 1'b0, 32'h7000, 0);
        ar_take(4'd0, 32'h7000);
        do_req(0, 1'b0, 32'h7004, 0);
        check("t6_ar_pending", 32'(arvalid), 1);
        do_reset(1);
        check("t6_arvalid", 32'(arvalid), 0);
        check("t6_awvalid", 32'(awvalid), 0);
        check("t6_wvalid", 32'(wvalid), 0);
        check("t6_data_ok", 32'(sram_data_ok), 0);
        do_req(0, 1'b0, 32'h8000, 0);
        ar_take(4'd0, 32'h8000);
        r_return(4'd0, 32'h88880000);
        check("t6_new_ok", 32'(sram_data_ok), 32'b01);
        check("t6_new_data", sram_rdata[31:0], 32'h88880000);
        step();

        // 5: port1 read A, write B, read C; B returns before any R
        do_req(1, 1'b0, 32'hA000, 0);
        ar_take(4'd1, 32'hA000);
        do_req(1, 1'b1, 32'hB000, 32'hBBBB0002);
        aw_take(4'd1, 32'hB000, 32'hBBBB0002);
        b_return(4'd1);
        check("t5_w_held", 32'(sram_data_ok), 0);
        do_req(1, 1'b0, 32'hC000, 0);
        ar_take(4'd1, 32'hC000);
        r_return(4'd1, 32'hAAAA0001);
        check("t5_ord_r1", 32'(sram_data_ok), 32'b10);
        check("t5_data_r1", sram_rdata[63:32], 32'hAAAA0001);
        @(posedge aclk);
        #2;
        check("t5_ord_w", 32'(sram_data_ok), 32'b10);
        @(posedge aclk);
        #2;
        check("t5_ord_wait", 32'(sram_data_ok), 0);
        r_return(4'd1, 32'hCCCC0003);
        check("t5_ord_r2", 32'(sram_data_ok), 32'b10);
        check("t5_data_r2", sram_rdata[63:32], 32'hCCCC0003);

        // Unknown IDs are accepted and produce no response
        r_return(4'd3, 32'h33333333);
        check("unk_rid", 32'(sram_data_ok), 0);
        b_return(4'd2);
        check("unk_bid", 32'(sram_data_ok), 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
